// File: rtl/ps2_mouse_packet_rx.sv
// PS/2 mouse receiver: sync+filter PS2_CLK, frame 11-bit bytes, assemble 3-byte packets (parity check: PS2_RX_PARITY_CHECK_EN).
// Latency: oTrig/oErr one cycle after the deciding sampling event (~FILTER_DEPTH+3 cycles after the PS2_CLK fall).
// Backpressure: none; the device cannot be stalled, so each packet is presented once as a single-cycle trigger.
module ps2_mouse_packet_rx #(
  parameter int FILTER_DEPTH   = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        PS2_CLK,
  input  logic        PS2_DAT,
  input  logic        iEn,
  output logic        oTrig,
  output logic [23:0] oData,
  output logic        oErr
);

  localparam int FW = $clog2(FILTER_DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t        state, state_nxt;
  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          filt_lvl;
  logic [FW-1:0] filt_cnt;
  logic          evt, run, busy, tmo_hit;
  logic          shift_en, stop_evt, parity_ok, frame_ok, frame_bad;
  logic [7:0]    shreg, byte0, byte1;
  logic [2:0]    bit_cnt;
  logic [1:0]    byte_idx;
  logic [TW-1:0] tmo_cnt;

  // Sampling event is the cycle the filtered clock commits to a falling level.
  assign evt     = filt_lvl && !clk_s2 && (filt_cnt == FW'(FILTER_DEPTH - 1));
  assign busy    = (state != IDLE) || (byte_idx != 2'd0);
  assign tmo_hit = busy && (tmo_cnt == TW'(TIMEOUT_CYCLES));

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
      filt_lvl <= 1'b1;
      filt_cnt <= '0;
    end else begin
      clk_s1 <= PS2_CLK;
      clk_s2 <= clk_s1;
      dat_s1 <= PS2_DAT;
      dat_s2 <= dat_s1;
      if (clk_s2 == filt_lvl) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_DEPTH - 1)) begin
        filt_lvl <= clk_s2;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!iEn || tmo_hit) begin
      state_nxt = IDLE;
    end else if (evt) begin
      case (state)
        IDLE:    if (!dat_s2) state_nxt = DATA;
        DATA:    if (bit_cnt == 3'd7) state_nxt = PARITY;
        PARITY:  state_nxt = STOP;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    run       = iEn && !tmo_hit && evt;
    shift_en  = run && (state == DATA);
    stop_evt  = run && (state == STOP);
    frame_ok  = stop_evt && dat_s2 && parity_ok;
    frame_bad = stop_evt && !(dat_s2 && parity_ok);
  end

`ifdef PS2_RX_PARITY_CHECK_EN
  logic par_bit;

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET)                            par_bit <= 1'b0;
    else if (run && (state == PARITY))     par_bit <= dat_s2;
  end

  assign parity_ok = ^{shreg, par_bit};
`else
  assign parity_ok = 1'b1;
`endif

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      shreg    <= '0;
      bit_cnt  <= '0;
      byte_idx <= '0;
      byte0    <= '0;
      byte1    <= '0;
      tmo_cnt  <= '0;
      oData    <= '0;
      oTrig    <= 1'b0;
      oErr     <= 1'b0;
    end else begin
      oTrig <= 1'b0;
      oErr  <= 1'b0;
      if (shift_en) begin
        shreg   <= {dat_s2, shreg[7:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end else if (state == IDLE) begin
        bit_cnt <= '0;
      end
      if (!iEn || tmo_hit || evt || !busy) tmo_cnt <= '0;
      else                                 tmo_cnt <= tmo_cnt + 1'b1;
      // Disable aborts silently; timeout and frame errors drop the partial packet.
      if (!iEn) begin
        byte_idx <= '0;
      end else if (tmo_hit || frame_bad) begin
        byte_idx <= '0;
        oErr     <= 1'b1;
      end else if (frame_ok) begin
        case (byte_idx)
          2'd0: begin
            if (!shreg[3]) begin
              oErr <= 1'b1;
            end else begin
              byte0    <= shreg;
              byte_idx <= 2'd1;
            end
          end
          2'd1: begin
            byte1    <= shreg;
            byte_idx <= 2'd2;
          end
          default: begin
            oData    <= {shreg, byte1, byte0};
            oTrig    <= 1'b1;
            byte_idx <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_mouse_packet_rx.sv
// Bench for ps2_mouse_packet_rx: directed packet scenarios plus a random byte stream
// checked against a packet-level reference model.
module tb_ps2_mouse_packet_rx;

  localparam int FD  = 8;
  localparam int TMO = 600;
  localparam int HP  = 25;

`ifdef PS2_RX_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic        PS2_CLK;
  logic        PS2_DAT;
  logic        iEn;
  logic        oTrig;
  logic [23:0] oData;
  logic        oErr;

  int          checks = 0;
  int          errors = 0;
  int          obs_err = 0;
  int          obs_both = 0;
  logic [23:0] obs_q[$];

  ps2_mouse_packet_rx #(.FILTER_DEPTH(FD), .TIMEOUT_CYCLES(TMO)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .PS2_CLK(PS2_CLK), .PS2_DAT(PS2_DAT),
    .iEn(iEn), .oTrig(oTrig), .oData(oData), .oErr(oErr)
  );

  always #5 CLOCK = ~CLOCK;

  always @(negedge CLOCK) begin
    if (oTrig) obs_q.push_back(oData);
    if (oErr) obs_err++;
    if (oTrig && oErr) obs_both++;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge CLOCK);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input bit glitch, input int gap);
    logic [10:0] bits;
    bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      PS2_DAT = bits[i];
      if (glitch) begin
        wait_cyc(8);
        PS2_CLK = 1'b0;
        wait_cyc(3);
        PS2_CLK = 1'b1;
        wait_cyc(HP - 11);
      end else begin
        wait_cyc(HP);
      end
      PS2_CLK = 1'b0;
      wait_cyc(HP);
      PS2_CLK = 1'b1;
    end
    PS2_DAT = 1'b1;
    wait_cyc(gap);
  endtask

  task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                             input bit glitch);
    send_frame(b0, 1'b0, 1'b0, glitch, 20);
    send_frame(b1, 1'b0, 1'b0, glitch, 20);
    send_frame(b2, 1'b0, 1'b0, glitch, 20);
  endtask

  task automatic test_reset;
    RESET = 1'b0; iEn = 1'b0; PS2_CLK = 1'b1; PS2_DAT = 1'b1;
    wait_cyc(5);
    checks++; if (oTrig !== 1'b0) begin errors++; $display("FAIL reset_trig: got %b want 0", oTrig); end
    checks++; if (oErr !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", oErr); end
    checks++; if (oData !== 24'h000000) begin errors++; $display("FAIL reset_data: got %h want 000000", oData); end
    RESET = 1'b1;
    wait_cyc(5);
    iEn = 1'b1;
    wait_cyc(5);
  endtask

  task automatic test_good_packet;
    int e0 = obs_err, t0 = obs_q.size();
    send_packet(8'h09, 8'h05, 8'hFB, 1'b0);
    checks++; if (obs_q.size() - t0 !== 1) begin errors++; $display("FAIL good_trigs: got %0d want 1", obs_q.size() - t0); end
    checks++; if (oData !== 24'hFB0509) begin errors++; $display("FAIL good_data: got %h want FB0509", oData); end
    checks++; if (obs_err - e0 !== 0) begin errors++; $display("FAIL good_errs: got %0d want 0", obs_err - e0); end
  endtask

  task automatic test_parity;
    int e0 = obs_err, t0 = obs_q.size();
    send_frame(8'h09, 1'b0, 1'b0, 1'b0, 20);
    send_frame(8'h05, 1'b1, 1'b0, 1'b0, 20);
    checks++; if (obs_err - e0 !== (PAR_EN ? 1 : 0)) begin errors++; $display("FAIL parity_err: got %0d want %0d", obs_err - e0, PAR_EN ? 1 : 0); end
    checks++; if (oData !== 24'hFB0509) begin errors++; $display("FAIL parity_hold: got %h want FB0509", oData); end
    checks++; if (obs_q.size() - t0 !== 0) begin errors++; $display("FAIL parity_notrig: got %0d want 0", obs_q.size() - t0); end
    send_packet(8'h08, 8'h00, 8'h00, 1'b0);
    checks++; if (obs_q.size() - t0 !== 1) begin errors++; $display("FAIL parity_trigs: got %0d want 1", obs_q.size() - t0); end
    checks++; if (oData !== (PAR_EN ? 24'h000008 : 24'h080509)) begin errors++; $display("FAIL parity_data: got %h want %h", oData, PAR_EN ? 24'h000008 : 24'h080509); end
    checks++; if (obs_err - e0 !== (PAR_EN ? 1 : 2)) begin errors++; $display("FAIL parity_errs: got %0d want %0d", obs_err - e0, PAR_EN ? 1 : 2); end
  endtask

  task automatic test_sync;
    int e0 = obs_err, t0 = obs_q.size();
    send_frame(8'h01, 1'b0, 1'b0, 1'b0, 20);
    checks++; if (obs_err - e0 !== 1) begin errors++; $display("FAIL sync_err: got %0d want 1", obs_err - e0); end
    send_packet(8'h18, 8'h02, 8'h03, 1'b0);
    checks++; if (obs_q.size() - t0 !== 1) begin errors++; $display("FAIL sync_trigs: got %0d want 1", obs_q.size() - t0); end
    checks++; if (oData !== 24'h030218) begin errors++; $display("FAIL sync_data: got %h want 030218", oData); end
    checks++; if (obs_err - e0 !== 1) begin errors++; $display("FAIL sync_errs: got %0d want 1", obs_err - e0); end
  endtask

  task automatic test_timeout;
    int e0 = obs_err, t0 = obs_q.size();
    send_frame(8'h09, 1'b0, 1'b0, 1'b0, 20);
    checks++; if (obs_err - e0 !== 0) begin errors++; $display("FAIL tmo_early: got %0d want 0", obs_err - e0); end
    wait_cyc(TMO + 100);
    checks++; if (obs_err - e0 !== 1) begin errors++; $display("FAIL tmo_err: got %0d want 1", obs_err - e0); end
    send_packet(8'h08, 8'h01, 8'h02, 1'b0);
    checks++; if (obs_q.size() - t0 !== 1) begin errors++; $display("FAIL tmo_trigs: got %0d want 1", obs_q.size() - t0); end
    checks++; if (oData !== 24'h020108) begin errors++; $display("FAIL tmo_data: got %h want 020108", oData); end
  endtask

  task automatic test_glitch;
    int e0 = obs_err, t0 = obs_q.size();
    send_packet(8'h09, 8'h05, 8'hFB, 1'b1);
    checks++; if (obs_q.size() - t0 !== 1) begin errors++; $display("FAIL glitch_trigs: got %0d want 1", obs_q.size() - t0); end
    checks++; if (oData !== 24'hFB0509) begin errors++; $display("FAIL glitch_data: got %h want FB0509", oData); end
    checks++; if (obs_err - e0 !== 0) begin errors++; $display("FAIL glitch_errs: got %0d want 0", obs_err - e0); end
  endtask

  task automatic test_enable;
    int e0 = obs_err, t0 = obs_q.size();
    send_frame(8'h09, 1'b0, 1'b0, 1'b0, 20);
    send_frame(8'h05, 1'b0, 1'b0, 1'b0, 20);
    iEn = 1'b0;
    wait_cyc(TMO + 100);
    checks++; if (obs_err - e0 !== 0) begin errors++; $display("FAIL en_errs: got %0d want 0", obs_err - e0); end
    checks++; if (obs_q.size() - t0 !== 0) begin errors++; $display("FAIL en_trigs: got %0d want 0", obs_q.size() - t0); end
    iEn = 1'b1;
    wait_cyc(10);
    send_packet(8'h08, 8'h00, 8'h00, 1'b0);
    checks++; if (oData !== 24'h000008) begin errors++; $display("FAIL en_data: got %h want 000008", oData); end
    checks++; if (obs_q.size() - t0 !== 1) begin errors++; $display("FAIL en_after: got %0d want 1", obs_q.size() - t0); end
  endtask

  task automatic test_reset_mid;
    int e0, t0;
    logic [7:0] b = 8'h09;
    PS2_DAT = 1'b0; wait_cyc(HP); PS2_CLK = 1'b0; wait_cyc(HP); PS2_CLK = 1'b1;
    for (int i = 0; i < 4; i++) begin
      PS2_DAT = b[i]; wait_cyc(HP); PS2_CLK = 1'b0; wait_cyc(HP); PS2_CLK = 1'b1;
    end
    RESET = 1'b0;
    #1;
    checks++; if (oData !== 24'h000000) begin errors++; $display("FAIL rst_data: got %h want 000000", oData); end
    checks++; if (oTrig !== 1'b0 || oErr !== 1'b0) begin errors++; $display("FAIL rst_pulses: got %b%b want 00", oTrig, oErr); end
    PS2_DAT = 1'b1;
    wait_cyc(50);
    RESET = 1'b1;
    wait_cyc(50);
    e0 = obs_err; t0 = obs_q.size();
    send_packet(8'h09, 8'h05, 8'hFB, 1'b0);
    checks++; if (obs_q.size() - t0 !== 1) begin errors++; $display("FAIL rst_trigs: got %0d want 1", obs_q.size() - t0); end
    checks++; if (oData !== 24'hFB0509) begin errors++; $display("FAIL rst_next: got %h want FB0509", oData); end
    checks++; if (obs_err - e0 !== 0) begin errors++; $display("FAIL rst_errs: got %0d want 0", obs_err - e0); end
  endtask

  // Reference: bytes accumulate into a list of up to three; any bad frame empties it,
  // an unsynchronised first byte is dropped, and three bytes make one packet.
  task automatic test_random;
    int e0 = obs_err, t0 = obs_q.size();
    int exp_err = 0;
    logic [7:0]  part[$];
    logic [23:0] exp_q[$];
    for (int n = 0; n < 24; n++) begin
      logic [7:0] b;
      bit bad_par, bad_stop;
      b        = 8'($urandom);
      bad_par  = ($urandom_range(0, 7) == 0);
      bad_stop = ($urandom_range(0, 9) == 0);
      send_frame(b, bad_par, bad_stop, 1'b0, $urandom_range(5, 100));
      if (bad_stop || (PAR_EN && bad_par)) begin
        part.delete();
        exp_err++;
      end else if (part.size() == 0 && b[3] == 1'b0) begin
        exp_err++;
      end else begin
        part.push_back(b);
        if (part.size() == 3) begin
          exp_q.push_back({part[2], part[1], part[0]});
          part.delete();
        end
      end
    end
    wait_cyc(TMO + 100);
    if (part.size() != 0) exp_err++;
    checks++; if (obs_err - e0 !== exp_err) begin errors++; $display("FAIL rand_errs: got %0d want %0d", obs_err - e0, exp_err); end
    checks++; if (obs_q.size() - t0 !== exp_q.size()) begin errors++; $display("FAIL rand_trigs: got %0d want %0d", obs_q.size() - t0, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && (t0 + i) < obs_q.size(); i++) begin
      checks++;
      if (obs_q[t0 + i] !== exp_q[i]) begin errors++; $display("FAIL rand_pkt%0d: got %h want %h", i, obs_q[t0 + i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset;
    test_good_packet;
    test_parity;
    test_sync;
    test_timeout;
    test_glitch;
    test_enable;
    test_reset_mid;
    test_random;
    checks++; if (obs_both !== 0) begin errors++; $display("FAIL trig_err_overlap: got %0d want 0", obs_both); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_mouse_packet_rx.md
# ps2_mouse_packet_rx

Receive side of the PS/2 mouse path. It samples the device-driven PS2_CLK/PS2_DAT lines and assembles 11-bit frames. It validates each frame, groups three bytes into one 24-bit movement packet, and presents that packet with a single-cycle trigger to the mouse position accumulator. It starts receiving only after the init stage grants `iEn`. It never drives the bus.

## Interface
- `FILTER_DEPTH`, default 8: number of consecutive identical synchronized samples required before PS2_CLK changes its filtered level.
- `TIMEOUT_CYCLES`, default 100000: maximum gap, in CLOCK cycles, between filtered PS2_CLK falling edges while a frame or packet is in progress (2 ms at 50 MHz).
- Reset is asynchronous and active-low.
- `CLOCK` (in, 1): system clock. All logic is on the rising edge.
- `RESET` (in, 1): asynchronous, active-low reset.
- `PS2_CLK` (in, 1): PS/2 clock line, device-driven, asynchronous to CLOCK.
- `PS2_DAT` (in, 1): PS/2 data line, asynchronous to CLOCK.
- `iEn` (in, 1): level enable from the init stage. High means the mouse is in stream mode.
- `oTrig` (out, 1): one-cycle pulse indicating that `oData` holds a new valid packet.
- `oData` (out, 24): packet contents.
  - `[7:0]` status byte. Bit 0 is left, bit 1 right, bit 2 middle, bit 3 is always 1, bit 4 is X sign, bit 5 is Y sign.
  - `[15:8]` X delta.
  - `[23:16]` Y delta.
- `oErr` (out, 1): one-cycle pulse on any discarded frame or packet.

## Operation
- **Input conditioning**
  - PS2_CLK and PS2_DAT each pass through a 2-flop synchronizer.
  - The synchronized PS2_CLK feeds a saturating filter counter. The filtered level flips only after `FILTER_DEPTH` consecutive samples at the opposite level.
  - A falling edge of the filtered clock is a sampling event. The synchronized PS2_DAT is sampled in the same cycle.
- **Frame FSM**: states IDLE, DATA, PARITY, STOP.
  - IDLE: a sampling event with data 0 (start bit) moves to DATA. Data 1 is ignored and the FSM stays in IDLE.
  - DATA: 8 sampling events fill the byte LSB-first. A 3-bit counter tracks the bits; after bit 7 the FSM moves to PARITY.
  - PARITY: capture the parity bit, then move to STOP.
  - STOP: the stop bit must be 1. On a good stop the byte is complete. Always return to IDLE.
- **Packet assembly**
  - A byte index 0..2 selects which slot of the packet a completed byte fills.
  - Byte 0 with bit 3 = 0 is a sync error. It is discarded, `oErr` pulses, and the index stays at 0.
  - Any frame error (bad stop bit, or parity error when checking is enabled) discards the whole partial packet, resets the index to 0 and pulses `oErr`.
  - When byte 2 completes, all three bytes load into `oData` and `oTrig` pulses. The index returns to 0.
- **Timeout**
  - The timeout counter clears on every sampling event and counts only while the FSM is not in IDLE or the byte index is not 0.
  - When it reaches `TIMEOUT_CYCLES` the receiver aborts: FSM goes to IDLE, index to 0, and `oErr` pulses.
- **Enable**
  - While `iEn` is 0, the FSM is held in IDLE with index 0 and the timeout counter at 0. `oTrig` and `oErr` stay at 0.
  - `iEn` falling mid-packet aborts silently, without an `oErr` pulse.
  - The synchronizers and filter keep running regardless of `iEn`.

## Timing
- **Reset values**: `oTrig`=0, `oErr`=0, `oData`=24'h000000. FSM in IDLE, index 0, all counters 0, filtered clock level 1.
- **Event latency**: a PS2_CLK fall reaches the sampling event 2 + `FILTER_DEPTH` cycles later, give or take 1 cycle.
- **Trigger timing**: `oTrig` and the `oData` update occur in the cycle after the sampling event for the stop bit of byte 2. `oTrig` is exactly 1 cycle wide.
- **Data hold**: `oData` holds its value until the next good packet. It is never modified on an error.
- **Error timing**: `oErr` pulses in the cycle after the sampling event that causes it, or the cycle after the timeout is reached. `oTrig` and `oErr` are never high in the same cycle.
- **Reset mid-frame**: all state clears immediately. The next start bit after reset release begins a fresh packet at byte 0.

## Configuration
- **Macro**: `PS2_RX_PARITY_CHECK_EN`.
- **Defined**: the received parity bit must make the 9 bits (data plus parity) odd. A mismatch is a frame error, which discards the packet and pulses `oErr`.
- **Undefined**: the parity bit is consumed but ignored, and only the start bit, stop bit, sync bit and timeout are checked.

## Test plan
- **Good packet**: `iEn`=1; send bytes 0x09, 0x05, 0xFB with correct parity at a 12.5 kHz PS2_CLK -> exactly one `oTrig` pulse, `oData`=24'hFB0509, `oErr` stays 0.
- **Parity error** (macro defined): corrupt the parity of byte 1 -> `oErr` pulses once, no `oTrig`, `oData` unchanged. A following good 0x08/0x00/0x00 packet gives `oData`=24'h000008.
- **Sync error**: leading byte 0x01 followed by 0x18, 0x02, 0x03 -> `oErr` pulses for 0x01 and `oTrig` is produced for packet 24'h030218.
- **Timeout**: send 0x09, then idle 100001 cycles, then 0x08, 0x01, 0x02 -> one `oErr` at the timeout, then `oTrig` with `oData`=24'h020108.
- **Glitch rejection**: inject 3-cycle low pulses on PS2_CLK between bits (`FILTER_DEPTH`=8) -> no extra bits; the packet 0x09/0x05/0xFB is received intact.
- **Enable and reset aborts**:
  - Drop `iEn` after byte 1 -> no `oErr`, no `oTrig`.
  - Assert `RESET` low mid-byte -> outputs read 0 and the next full packet is received correctly.
